// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register in front of the execute-stage ALU. It captures the
// decoded instruction each cycle and resolves RAW hazards by forwarding from
// the EX/MEM and MEM/WB stages. EX/MEM has priority, and register 0 is never
// forwarded. Stall holds the instruction, but a held instruction still picks
// up results that arrive at EX/MEM or MEM/WB during the stall. Flush inserts
// a bubble (nop select, no write) and takes priority over stall.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   stall_i, flush_i         hold / bubble-insert controls
//   in_valid, sel_in         decoded instruction valid and ALU op
//   rs/rt/rd_addr_in         source and destination register addresses
//   rs/rt_data_in, imm_in    register-file reads and extended immediate
//   use_imm_in, reg_write_in operand-B select and write-back enable
//   exmem_we/rd/data         EX/MEM forwarding source
//   memwb_we/rd/data         MEM/WB forwarding source
//   out_valid, alu_sel       registered valid and ALU select
//   alu_a, alu_b             registered ALU operands
//   rd_out, reg_write_out    registered destination and write enable
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             in_valid,
  input  logic [2:0]       sel_in,
  input  logic [RADDR-1:0] rs_addr_in,
  input  logic [RADDR-1:0] rt_addr_in,
  input  logic [RADDR-1:0] rd_addr_in,
  input  logic [WIDTH-1:0] rs_data_in,
  input  logic [WIDTH-1:0] rt_data_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             use_imm_in,
  input  logic             reg_write_in,
  input  logic             exmem_we,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic             memwb_we,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             out_valid,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [RADDR-1:0] rd_out,
  output logic             reg_write_out
);

  localparam logic [2:0] SEL_NOP = 3'b000;

  // Forwarding mux: EX/MEM is the younger producer, so it wins when both
  // stages target the same register. Register 0 is hard-wired and never
  // forwarded.
  function automatic logic [WIDTH-1:0] fwd(
    input logic [RADDR-1:0] addr,
    input logic [WIDTH-1:0] regval,
    input logic             ex_we,
    input logic [RADDR-1:0] ex_rd,
    input logic [WIDTH-1:0] ex_data,
    input logic             mw_we,
    input logic [RADDR-1:0] mw_rd,
    input logic [WIDTH-1:0] mw_data
  );
    logic [WIDTH-1:0] res;
    res = regval;
    if (addr != '0) begin
      if (ex_we && (ex_rd == addr))
        res = ex_data;
      else if (mw_we && (mw_rd == addr))
        res = mw_data;
    end
    return res;
  endfunction

  // Source addresses and operand-B select of the instruction currently held,
  // kept so that a stalled instruction can keep re-forwarding.
  logic [RADDR-1:0] rs_held_p1;
  logic [RADDR-1:0] rt_held_p1;
  logic             use_imm_held_p1;

  logic [WIDTH-1:0] load_a_p0;
  logic [WIDTH-1:0] load_b_p0;
  logic [WIDTH-1:0] hold_a_p1;
  logic [WIDTH-1:0] hold_b_p1;

  // ---- p0: decode-side operand selection (new instruction) ----
  always_comb begin
    load_a_p0 = fwd(rs_addr_in, rs_data_in, exmem_we, exmem_rd, exmem_data,
                    memwb_we, memwb_rd, memwb_data);
    load_b_p0 = use_imm_in ? imm_in
                           : fwd(rt_addr_in, rt_data_in, exmem_we, exmem_rd,
                                 exmem_data, memwb_we, memwb_rd, memwb_data);
  end

  // ---- p1: refresh of the held operands while stalled ----
  // The held operand value is the "register value" fed back into the
  // forwarding mux, so with no match it simply recirculates.
  always_comb begin
    hold_a_p1 = fwd(rs_held_p1, alu_a, exmem_we, exmem_rd, exmem_data,
                    memwb_we, memwb_rd, memwb_data);
    hold_b_p1 = use_imm_held_p1 ? alu_b
                                : fwd(rt_held_p1, alu_b, exmem_we, exmem_rd,
                                      exmem_data, memwb_we, memwb_rd,
                                      memwb_data);
  end

  // ---- p0 -> p1: ID/EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      alu_sel         <= SEL_NOP;
      alu_a           <= '0;
      alu_b           <= '0;
      rd_out          <= '0;
      reg_write_out   <= 1'b0;
      rs_held_p1      <= '0;
      rt_held_p1      <= '0;
      use_imm_held_p1 <= 1'b0;
    end else if (flush_i) begin
      // Bubble: nop select so the ALU output is harmless; operands keep
      // their last values since nothing consumes them.
      out_valid     <= 1'b0;
      alu_sel       <= SEL_NOP;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
    end else if (stall_i) begin
      // A held bubble needs no refresh.
      if (out_valid) begin
        alu_a <= hold_a_p1;
        alu_b <= hold_b_p1;
      end
    end else begin
      out_valid       <= in_valid;
      alu_sel         <= in_valid ? sel_in : SEL_NOP;
      reg_write_out   <= in_valid & reg_write_in;
      rd_out          <= rd_addr_in;
      alu_a           <= load_a_p0;
      alu_b           <= load_b_p0;
      rs_held_p1      <= rs_addr_in;
      rt_held_p1      <= rt_addr_in;
      use_imm_held_p1 <= use_imm_in;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the execute-stage ALU; drives the ALU's 3-bit select and its two WIDTH-bit operands.
- Captures decoded instruction fields each cycle.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Supports stall (hold) and flush (bubble insertion).
- Keeps held operands fresh while stalled.

Parameters:
- WIDTH, 32, datapath width of operands and results.
- RADDR, 5, register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold current contents.
- flush_i  input  1  replace contents with a bubble on next edge.
- in_valid  input  1  decode stage presents a valid instruction.
- sel_in  input  3  ALU operation code from decode (001 add, 010 and, 011 or, 100 xor, 101 slt, 110 mul, 111 pass-a, 000 nop).
- rs_addr_in  input  RADDR  source register A address.
- rt_addr_in  input  RADDR  source register B address.
- rd_addr_in  input  RADDR  destination address.
- rs_data_in  input  WIDTH  register-file read A.
- rt_data_in  input  WIDTH  register-file read B.
- imm_in  input  WIDTH  already-extended immediate.
- use_imm_in  input  1  operand B = imm_in instead of rt.
- reg_write_in  input  1  instruction writes rd.
- exmem_we  input  1  EX/MEM stage will write back.
- exmem_rd  input  RADDR  EX/MEM destination.
- exmem_data  input  WIDTH  EX/MEM result.
- memwb_we  input  1  MEM/WB stage writing back.
- memwb_rd  input  RADDR  MEM/WB destination.
- memwb_data  input  WIDTH  MEM/WB result.
- out_valid  output  1  registered instruction valid.
- alu_sel  output  3  registered ALU select.
- alu_a  output  WIDTH  registered operand A.
- alu_b  output  WIDTH  registered operand B.
- rd_out  output  RADDR  registered destination.
- reg_write_out  output  1  registered write enable; 0 whenever out_valid=0.

Behaviour:
- Clocking: single clock; reset asynchronous, active-low.
- Reset: all outputs 0, including alu_sel=000 (nop). Internal held rs/rt addresses and use_imm flag also clear to 0.
- Forwarding function fwd(addr, regval):
  - Address 0 is never forwarded; returns regval.
  - Else if exmem_we and exmem_rd==addr, returns exmem_data (highest priority).
  - Else if memwb_we and memwb_rd==addr, returns memwb_data.
  - Else returns regval.
- Priority per rising edge: flush_i > stall_i > load.
- Flush:
  - out_valid=0, reg_write_out=0, alu_sel=000, rd_out=0.
  - alu_a/alu_b hold their previous values.
  - Flush with stall asserted still produces the bubble.
- Stall, with out_valid=1:
  - All fields hold.
  - alu_a <= fwd(held_rs, alu_a).
  - alu_b <= use_imm_held ? alu_b : fwd(held_rt, alu_b).
  - This refreshes operands when a producer reaches EX/MEM or MEM/WB during the stall.
- Stall, with out_valid=0: everything holds unchanged.
- Load (no stall, no flush):
  - out_valid <= in_valid.
  - alu_sel <= in_valid ? sel_in : 000.
  - reg_write_out <= in_valid & reg_write_in.
  - rd_out <= rd_addr_in.
  - alu_a <= fwd(rs_addr_in, rs_data_in).
  - alu_b <= use_imm_in ? imm_in : fwd(rt_addr_in, rt_data_in).
  - Held rs/rt addresses and use_imm latch from the inputs.
- Latency: exactly one cycle from decode inputs to ALU-facing outputs; no combinational path from inputs to outputs.
- Reset mid-operation: asserting rst_n=0 clears state immediately, regardless of clk. The first edge after deassertion performs a normal load/stall/flush decision.
- Bubbles (out_valid=0) always present alu_sel=000, so the ALU produces y=0/zero=1 harmlessly.
- Both forwarding sources matching the same address: EX/MEM wins.

Test Plan:
- Reset: rst_n=0 asynchronously between edges -> all outputs 0 at once; after release with in_valid=1, sel_in=001, rs_data=5, rt_data=7, no hazards -> next edge out_valid=1, alu_sel=001, alu_a=5, alu_b=7.
- Forward priority: rs_addr_in=3, exmem_we=1/exmem_rd=3/exmem_data=0xAAAA, memwb_we=1/memwb_rd=3/memwb_data=0x5555 -> alu_a=0xAAAA. Repeat with exmem_we=0 -> alu_a=0x5555. With rs_addr_in=0 and both matching 0 -> alu_a=rs_data_in.
- Immediate: use_imm_in=1, imm_in=0xFFFFFFF0, rt_addr_in=4 matching exmem_rd -> alu_b=0xFFFFFFF0.
- Stall refresh: load add with rt=6, rt_data=1; stall 2 cycles; in second stall cycle memwb_we=1/rd=6/data=9 -> alu_b becomes 9. alu_sel, rd_out and out_valid stay unchanged throughout.
- Flush vs stall: flush_i=1 and stall_i=1 on the same edge -> out_valid=0, reg_write_out=0, alu_sel=000. Following edge with in_valid=0 -> remains bubble.
- Back-to-back: three consecutive loads with sel 010, 011, 100 -> outputs track with exactly one-cycle latency; no dropped or duplicated instruction.
